// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared constants, load-type encodings and lane helper for the
// writeback stage.
package wb_stage_pkg;

  localparam int          XLEN_DEF  = 64;
  localparam logic [63:0] ZERO_WORD = 64'h0000_0000_0000_0000;

  typedef enum logic [2:0] {
    LD_LB  = 3'd0,
    LD_LH  = 3'd1,
    LD_LW  = 3'd2,
    LD_LD  = 3'd3,
    LD_LBU = 3'd4,
    LD_LHU = 3'd5,
    LD_LWU = 3'd6
  } ld_type_e;

  // Byte offset of the lane actually read: the address offset is masked down
  // to the access size, so misaligned accesses fall back to the aligned lane.
  function automatic logic [2:0] lane_offset(input logic [2:0] addr_lo,
                                             input ld_type_e  ld_type);
    logic [2:0] off;
    case (ld_type)
      LD_LB, LD_LBU: off = addr_lo;
      LD_LH, LD_LHU: off = {addr_lo[2:1], 1'b0};
      LD_LW, LD_LWU: off = {addr_lo[2], 2'b00};
      default:       off = 3'b000;
    endcase
    return off;
  endfunction

endpackage

// File: rtl/wb_stage_if.sv
// wb_stage_if: MEM-to-WB retirement bus with a valid/ready handshake.
// master = MEM stage (drives the instruction), slave = writeback stage.
interface wb_stage_if #(
  parameter int XLEN = wb_stage_pkg::XLEN_DEF
) ();

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [4:0]      in_rd;
  logic            in_rd_we;
  logic [XLEN-1:0] in_alu_res;
  logic            in_is_load;
  logic [2:0]      in_ld_type;
  logic [XLEN-1:0] in_mem_rdata;

  modport master (
    output in_valid, in_pc, in_rd, in_rd_we, in_alu_res,
           in_is_load, in_ld_type, in_mem_rdata,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_pc, in_rd, in_rd_we, in_alu_res,
           in_is_load, in_ld_type, in_mem_rdata,
    output in_ready
  );

endinterface

// File: rtl/wb_stage_load_align.sv
// load_align: combinational load data extraction. Picks the byte/half/word
// lane from the raw doubleword and sign- or zero-extends it; non-loads pass
// the ALU result through.
module load_align
  import wb_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            is_load,
  input  ld_type_e        ld_type,
  input  logic [XLEN-1:0] alu_res,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [XLEN-1:0] result
);

  logic [2:0]  off_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic [31:0] word_s;

  // Lane extraction from the masked offset, then extension by load type.
  always_comb begin
    off_s  = lane_offset(alu_res[2:0], ld_type);
    byte_s = mem_rdata[{off_s, 3'b000} +: 8];
    half_s = mem_rdata[{off_s, 3'b000} +: 16];
    word_s = mem_rdata[{off_s, 3'b000} +: 32];
    if (is_load) begin
      case (ld_type)
        LD_LB:   result = {{(XLEN-8){byte_s[7]}}, byte_s};
        LD_LH:   result = {{(XLEN-16){half_s[15]}}, half_s};
        LD_LW:   result = {{(XLEN-32){word_s[31]}}, word_s};
        LD_LBU:  result = {{(XLEN-8){1'b0}}, byte_s};
        LD_LHU:  result = {{(XLEN-16){1'b0}}, half_s};
        LD_LWU:  result = {{(XLEN-32){1'b0}}, word_s};
        default: result = mem_rdata;
      endcase
    end else begin
      result = alu_res;
    end
  end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: single-entry writeback stage. Registers a retiring instruction,
// drives the register-file write port one cycle later and counts commits.
// Optional feature macro WB_COMMIT_TRACE_EN adds commit_valid/commit_pc.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  wb_stage_if.slave        mem_bus,
  input  logic             hold,
  input  logic             flush,
  output logic [4:0]       waddr,
  output logic [XLEN-1:0]  wdata,
  output logic             we,
  output logic [CNT_W-1:0] retired_cnt
`ifdef WB_COMMIT_TRACE_EN
  ,
  output logic             commit_valid,
  output logic [XLEN-1:0]  commit_pc
`endif
);

  logic             valid_r;
  logic             rd_we_r;
  logic [4:0]       rd_r;
  logic [XLEN-1:0]  data_r;
  logic [CNT_W-1:0] cnt_r;
  logic [XLEN-1:0]  ld_result_s;
  logic             accept_s;
  logic             commit_s;

  load_align #(
    .XLEN (XLEN)
  ) u_load_align (
    .is_load   (mem_bus.in_is_load),
    .ld_type   (ld_type_e'(mem_bus.in_ld_type)),
    .alu_res   (mem_bus.in_alu_res),
    .mem_rdata (mem_bus.in_mem_rdata),
    .result    (ld_result_s)
  );

  assign mem_bus.in_ready = ~hold;
  assign waddr            = rd_r;
  assign wdata            = data_r;
  assign retired_cnt      = cnt_r;

  // Handshake and commit qualification; hold masks the write in the same cycle.
  always_comb begin
    accept_s = mem_bus.in_valid & ~hold & ~flush;
    commit_s = valid_r & ~hold;
    we       = commit_s & rd_we_r & (rd_r != 5'd0);
  end

  // Held entry: flush drops it, an accept replaces it, hold freezes it,
  // otherwise it retires and the stage goes empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_r <= 1'b0;
      rd_we_r <= 1'b0;
      rd_r    <= 5'd0;
      data_r  <= XLEN'(ZERO_WORD);
    end else if (flush) begin
      valid_r <= 1'b0;
    end else if (accept_s) begin
      valid_r <= 1'b1;
      rd_we_r <= mem_bus.in_rd_we;
      rd_r    <= mem_bus.in_rd;
      data_r  <= ld_result_s;
    end else if (hold) begin
      valid_r <= valid_r;
    end else begin
      valid_r <= 1'b0;
    end
  end

  // Retired-instruction counter, wrapping naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= '0;
    end else if (commit_s) begin
      cnt_r <= cnt_r + CNT_W'(1'b1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

`ifdef WB_COMMIT_TRACE_EN
  logic [XLEN-1:0] pc_r;

  // PC of the held entry, reported alongside each commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_r <= XLEN'(ZERO_WORD);
    end else if (accept_s) begin
      pc_r <= mem_bus.in_pc;
    end else begin
      pc_r <= pc_r;
    end
  end

  assign commit_valid = commit_s;
  assign commit_pc    = pc_r;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed bench for wb_stage with a per-cycle behavioural model
// and hand-computed literal checks.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        hold = 1'b0;
  logic        flush = 1'b0;
  logic [4:0]  waddr;
  logic [63:0] wdata;
  logic        we;
  logic [63:0] retired_cnt;
`ifdef WB_COMMIT_TRACE_EN
  logic        commit_valid;
  logic [63:0] commit_pc;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  wb_stage_if #(.XLEN(64)) bus ();

  wb_stage #(.XLEN(64), .CNT_W(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_bus     (bus),
    .hold        (hold),
    .flush       (flush),
    .waddr       (waddr),
    .wdata       (wdata),
    .we          (we),
    .retired_cnt (retired_cnt)
`ifdef WB_COMMIT_TRACE_EN
    ,
    .commit_valid(commit_valid),
    .commit_pc   (commit_pc)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Expected load value from size/offset arithmetic on the doubleword.
  function automatic logic [63:0] exp_load(input logic [2:0] t, input logic [63:0] addr,
                                           input logic [63:0] d);
    int size;
    int off;
    logic [63:0] mask;
    logic [63:0] v;
    case (t)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2, 3'd6: size = 4;
      default:    size = 8;
    endcase
    off = (int'(addr[2:0]) / size) * size;
    v   = d >> (8 * off);
    if (size == 8) return v;
    mask = (64'd1 << (8 * size)) - 64'd1;
    v    = v & mask;
    if (t < 3'd3 && v[8*size-1]) v = v | ~mask;
    return v;
  endfunction

  // Model of the stage: one optional entry plus a commit count.
  logic        m_valid = 1'b0;
  logic        m_rd_we = 1'b0;
  logic [4:0]  m_rd    = 5'd0;
  logic [63:0] m_data  = 64'd0;
  logic [63:0] m_pc    = 64'd0;
  logic [63:0] m_cnt   = 64'd0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid = 1'b0; m_rd_we = 1'b0; m_rd = 5'd0; m_data = 64'd0; m_pc = 64'd0; m_cnt = 64'd0;
    end else begin
      if (m_valid && !hold) m_cnt = m_cnt + 64'd1;
      if (flush) begin
        m_valid = 1'b0;
      end else if (!hold) begin
        if (bus.in_valid) begin
          m_valid = 1'b1;
          m_rd    = bus.in_rd;
          m_rd_we = bus.in_rd_we;
          m_pc    = bus.in_pc;
          m_data  = bus.in_is_load ? exp_load(bus.in_ld_type, bus.in_alu_res, bus.in_mem_rdata)
                                   : bus.in_alu_res;
        end else begin
          m_valid = 1'b0;
        end
      end
    end
  end

  // Compare process: every falling edge, DUT outputs against the model.
  always @(negedge clk) begin
    chk("in_ready", {63'd0, bus.in_ready}, {63'd0, !hold});
    chk("we", {63'd0, we}, {63'd0, m_valid && m_rd_we && (m_rd != 5'd0) && !hold});
    chk("waddr", {59'd0, waddr}, {59'd0, m_rd});
    chk("wdata", wdata, m_data);
    chk("retired_cnt", retired_cnt, m_cnt);
`ifdef WB_COMMIT_TRACE_EN
    chk("commit_valid", {63'd0, commit_valid}, {63'd0, m_valid && !hold});
    if (m_valid) chk("commit_pc", commit_pc, m_pc);
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic [4:0] rd, input logic rwe, input logic [63:0] alu,
                     input logic ld, input logic [2:0] lt, input logic [63:0] rdata);
    bus.in_valid     = v;
    bus.in_rd        = rd;
    bus.in_rd_we     = rwe;
    bus.in_alu_res   = alu;
    bus.in_is_load   = ld;
    bus.in_ld_type   = lt;
    bus.in_mem_rdata = rdata;
    bus.in_pc        = bus.in_pc + 64'd4;
  endtask

  typedef struct {
    logic [2:0]  t;
    logic [63:0] a;
    logic [63:0] d;
    logic [63:0] e;
  } ld_vec_t;

  ld_vec_t tbl[9];
  logic [63:0] c0;

  initial begin
    tbl[0] = '{3'd0, 64'h1005, 64'h0000_80FF_0000_0000, 64'hFFFF_FFFF_FFFF_FF80}; // LB
    tbl[1] = '{3'd4, 64'h1005, 64'h0000_80FF_0000_0000, 64'h0000_0000_0000_0080}; // LBU
    tbl[2] = '{3'd1, 64'h2003, 64'h1122_3344_8566_7788, 64'hFFFF_FFFF_FFFF_8566}; // LH misaligned
    tbl[3] = '{3'd2, 64'h2006, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321}; // LW misaligned
    tbl[4] = '{3'd3, 64'h2010, 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567}; // LD
    tbl[5] = '{3'd5, 64'h2001, 64'h0000_0000_0000_F00D, 64'h0000_0000_0000_F00D}; // LHU
    tbl[6] = '{3'd6, 64'h2004, 64'hCAFE_BABE_1234_5678, 64'h0000_0000_CAFE_BABE}; // LWU
    tbl[7] = '{3'd0, 64'h2002, 64'h0000_0000_007F_0000, 64'h0000_0000_0000_007F}; // LB positive
    tbl[8] = '{3'd2, 64'h2001, 64'h0000_0000_8000_0001, 64'hFFFF_FFFF_8000_0001}; // LW offset 1

    bus.in_pc = 64'h8000_0000;
    put(1'b0, 5'd0, 1'b0, 64'd0, 1'b0, 3'd0, 64'd0);
    repeat (3) tick();
    @(negedge clk);
    chk("rst_we", {63'd0, we}, 64'd0);
    chk("rst_cnt", retired_cnt, 64'd0);
    chk("rst_waddr", {59'd0, waddr}, 64'd0);
    chk("rst_wdata", wdata, 64'd0);

    // Release reset together with the first load; accepted on the next edge.
    @(posedge clk); #1;
    rst = 1'b1;
    put(1'b1, 5'd7, 1'b1, tbl[0].a, 1'b1, tbl[0].t, tbl[0].d);
    tick();
    for (int i = 0; i < 9; i++) begin
      if (i < 8) put(1'b1, 5'(8 + i), 1'b1, tbl[i+1].a, 1'b1, tbl[i+1].t, tbl[i+1].d);
      else       put(1'b0, 5'd0, 1'b0, 64'd0, 1'b0, 3'd0, 64'd0);
      @(negedge clk);
      chk("ld_we", {63'd0, we}, 64'd1);
      chk("ld_waddr", {59'd0, waddr}, 64'(7 + i));
      chk("ld_wdata", wdata, tbl[i].e);
      chk("ld_cnt", retired_cnt, 64'(i));
      tick();
    end

    // Write to x0: no write, still counted.
    put(1'b1, 5'd0, 1'b1, 64'h1234, 1'b0, 3'd0, 64'd0);
    tick();
    put(1'b0, 5'd0, 1'b0, 64'd0, 1'b0, 3'd0, 64'd0);
    c0 = m_cnt;
    @(negedge clk);
    chk("x0_we", {63'd0, we}, 64'd0);
    chk("x0_wdata", wdata, 64'h1234);
    tick();
    @(negedge clk);
    chk("x0_cnt", retired_cnt, c0 + 64'd1);

    // Hold for three cycles, then a single write.
    tick();
    put(1'b1, 5'd5, 1'b1, 64'hABCD, 1'b0, 3'd0, 64'd0);
    tick();
    put(1'b0, 5'd0, 1'b0, 64'd0, 1'b0, 3'd0, 64'd0);
    hold = 1'b1;
    c0 = m_cnt;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_we", {63'd0, we}, 64'd0);
      chk("hold_cnt", retired_cnt, c0);
      tick();
    end
    hold = 1'b0;
    @(negedge clk);
    chk("unhold_we", {63'd0, we}, 64'd1);
    chk("unhold_waddr", {59'd0, waddr}, 64'd5);
    chk("unhold_wdata", wdata, 64'hABCD);
    tick();
    @(negedge clk);
    chk("unhold_we_after", {63'd0, we}, 64'd0);
    chk("unhold_cnt", retired_cnt, c0 + 64'd1);

    // Flush with hold drops the held entry.
    tick();
    put(1'b1, 5'd9, 1'b1, 64'h55, 1'b0, 3'd0, 64'd0);
    tick();
    put(1'b0, 5'd0, 1'b0, 64'd0, 1'b0, 3'd0, 64'd0);
    hold = 1'b1; flush = 1'b1;
    c0 = m_cnt;
    @(negedge clk);
    chk("flush_we", {63'd0, we}, 64'd0);
    tick();
    hold = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_we_after", {63'd0, we}, 64'd0);
    chk("flush_cnt", retired_cnt, c0);

    // Flush blocks acceptance on an empty stage.
    tick();
    put(1'b1, 5'd10, 1'b1, 64'h99, 1'b0, 3'd0, 64'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    put(1'b0, 5'd0, 1'b0, 64'd0, 1'b0, 3'd0, 64'd0);
    @(negedge clk);
    chk("flush_block_we", {63'd0, we}, 64'd0);
    chk("flush_block_cnt", retired_cnt, c0);

    // Reset in the middle of a valid entry.
    tick();
    put(1'b1, 5'd12, 1'b1, 64'h77, 1'b0, 3'd0, 64'd0);
    tick();
    put(1'b0, 5'd0, 1'b0, 64'd0, 1'b0, 3'd0, 64'd0);
    chk("pre_rst_we", {63'd0, we}, 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_we", {63'd0, we}, 64'd0);
    chk("mid_rst_cnt", retired_cnt, 64'd0);
    chk("mid_rst_waddr", {59'd0, waddr}, 64'd0);
    chk("mid_rst_wdata", wdata, 64'd0);
    tick();
    tick();

    // Ten back-to-back accepts from a fresh reset.
    rst = 1'b1;
    put(1'b1, 5'd1, 1'b1, 64'h100, 1'b0, 3'd0, 64'd0);
    tick();
    for (int i = 0; i < 10; i++) begin
      if (i < 9) put(1'b1, 5'(i + 2), 1'b1, 64'(256 * (i + 2)), 1'b0, 3'd0, 64'd0);
      else       put(1'b0, 5'd0, 1'b0, 64'd0, 1'b0, 3'd0, 64'd0);
      @(negedge clk);
      chk("b2b_we", {63'd0, we}, 64'd1);
      chk("b2b_waddr", {59'd0, waddr}, 64'(i + 1));
      tick();
    end
    @(negedge clk);
    chk("b2b_we_end", {63'd0, we}, 64'd0);
    chk("b2b_cnt", retired_cnt, 64'd10);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
